// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader writing a length/checksum framed image into instruction memory
// Optional inter-byte timeout: define IMEM_LOADER_TIMEOUT_EN.
module imem_loader #(
    parameter int          MEM_BYTES      = 109,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam logic [15:0] MAX_LEN = 16'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state, state_n;
    logic [15:0] len, len_n;
    logic [15:0] cnt, cnt_n;
    logic [7:0]  acc, acc_n;
    logic        mem_we_n;
    logic [31:0] mem_addr_n;
    logic [7:0]  mem_wdata_n;
    logic [1:0]  err_code_n;
    logic        accept;
    logic [15:0] full_len;

    assign in_ready = (state == S_IDLE) || (state == S_LEN_HI) ||
                      (state == S_PAYLOAD) || (state == S_CHECK);
    assign accept   = in_valid && in_ready;
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);
    assign cpu_hold = (state != S_DONE);
    assign full_len = {in_data, len[7:0]};

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt, tcnt_n;
    logic          timing;

    assign timing = (state == S_LEN_HI) || (state == S_PAYLOAD) || (state == S_CHECK);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            len       <= 16'h0;
            cnt       <= 16'h0;
            acc       <= 8'h0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 8'h0;
            err_code  <= 2'd0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            cnt       <= cnt_n;
            acc       <= acc_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            err_code  <= err_code_n;
        end
    end

`ifdef IMEM_LOADER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt_n;
        end
    end
`endif

    always_comb begin
        state_n     = state;
        len_n       = len;
        cnt_n       = cnt;
        acc_n       = acc;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        err_code_n  = err_code;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    len_n   = {8'h0, in_data};
                    state_n = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_n = full_len;
                    cnt_n = 16'h0;
                    acc_n = 8'h0;
                    if (full_len > MAX_LEN) begin
                        state_n    = S_ERROR;
                        err_code_n = 2'd1;
                    end else if (full_len == 16'h0) begin
                        state_n = S_CHECK;
                    end else begin
                        state_n = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    mem_we_n    = 1'b1;
                    mem_addr_n  = BASE_ADDR + {16'h0, cnt};
                    mem_wdata_n = in_data;
                    acc_n       = acc + in_data;
                    cnt_n       = cnt + 16'd1;
                    if (cnt == len - 16'd1) begin
                        state_n = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (in_data == acc) begin
                        state_n = S_DONE;
                    end else begin
                        state_n    = S_ERROR;
                        err_code_n = 2'd2;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    state_n    = S_IDLE;
                    err_code_n = 2'd0;
                    len_n      = 16'h0;
                    cnt_n      = 16'h0;
                    acc_n      = 8'h0;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

`ifdef IMEM_LOADER_TIMEOUT_EN
        // An accepted byte on the expiry edge wins over the timeout.
        tcnt_n = '0;
        if (timing && !accept) begin
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state_n    = S_ERROR;
                err_code_n = 2'd3;
            end else begin
                tcnt_n = tcnt + 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a frame-level model
module tb_imem_loader;

    localparam int MEM = 109;
    localparam int TO  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h0;
    logic        in_ready;
    logic        restart = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    imem_loader #(.MEM_BYTES(MEM), .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0]  frame_q[$];
    logic [39:0] wr_q[$];
    int          wr_cyc[$];
    logic [39:0] exp_wr[$];
    logic        exp_done;
    logic [1:0]  exp_code;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_q.push_back({mem_addr, mem_wdata});
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) check("ready_wait", 0, 1);
        tick(1);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    // Frame-level reference: what memory should see and how the load should end.
    task automatic model_frame();
        int   n;
        logic [7:0] sum;
        exp_wr.delete();
        n = {frame_q[1], frame_q[0]};
        if (n > MEM) begin
            exp_done = 1'b0;
            exp_code = 2'd1;
            return;
        end
        sum = 8'h0;
        for (int k = 0; k < n; k++) begin
            exp_wr.push_back({32'(k), frame_q[2+k]});
            sum = sum + frame_q[2+k];
        end
        exp_done = (frame_q[2+n] == sum);
        exp_code = exp_done ? 2'd0 : 2'd2;
    endtask

    task automatic make_frame(input int n, input bit bad);
        logic [7:0] sum = 8'h0;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        if (n > MEM) return;
        for (int k = 0; k < n; k++) begin
            b = $urandom;
            frame_q.push_back(b);
            sum = sum + b;
        end
        frame_q.push_back(bad ? sum + 8'(1 + $urandom_range(0, 254)) : sum);
    endtask

    task automatic run_frame(input string tag, input int max_gap);
        model_frame();
        wr_q.delete();
        wr_cyc.delete();
        foreach (frame_q[i]) begin
            send_byte(frame_q[i]);
            if (max_gap > 0 && i != frame_q.size() - 1) tick($urandom_range(1, max_gap));
        end
        tick(2);
        check({tag, "_done"}, done, exp_done);
        check({tag, "_error"}, error, !exp_done);
        check({tag, "_code"}, err_code, exp_code);
        check({tag, "_hold"}, cpu_hold, !exp_done);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_nwr"}, wr_q.size(), exp_wr.size());
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
            check({tag, "_wr"}, wr_q[i], exp_wr[i]);
            if (max_gap == 0) check({tag, "_wrcyc"}, wr_cyc[i], wr_cyc[0] + i);
        end
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check({tag, "_rs_ready"}, in_ready, 1);
        check({tag, "_rs_done"}, done, 0);
        check({tag, "_rs_error"}, error, 0);
        check({tag, "_rs_code"}, err_code, 0);
        check({tag, "_rs_hold"}, cpu_hold, 1);
    endtask

    task automatic load_list(input logic [7:0] a[]);
        frame_q.delete();
        foreach (a[i]) frame_q.push_back(a[i]);
    endtask

    initial begin
        tick(3);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_code", err_code, 0);
        reset = 1'b0;
        tick(1);
        check("idle_ready", in_ready, 1);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("idle_restart_ignored", in_ready, 1);

        load_list('{8'h04, 8'h00, 8'h33, 8'h03, 8'h94, 8'h00, 8'hCA});
        run_frame("good", 0);
        check("good_w0", exp_wr.size() == 4 ? exp_wr[0] : 0, {32'd0, 8'h33});
        do_restart("good");

        load_list('{8'h04, 8'h00, 8'h33, 8'h03, 8'h94, 8'h00, 8'hCB});
        run_frame("badsum", 0);
        do_restart("badsum");

        load_list('{8'h6E, 8'h00});
        run_frame("ovf", 0);
        do_restart("ovf");

        load_list('{8'h6D, 8'h00});
        for (int k = 0; k < MEM; k++) frame_q.push_back(8'(k * 7 + 1));
        frame_q.push_back(8'h0);
        run_frame("maxlen", 0);
        do_restart("maxlen");

        load_list('{8'h00, 8'h00, 8'h00});
        run_frame("zero", 0);
        do_restart("zero");
        load_list('{8'h00, 8'h00, 8'h01});
        run_frame("zerobad", 0);
        do_restart("zerobad");

        load_list('{8'h04, 8'h00, 8'h33, 8'h03, 8'h94, 8'h00, 8'hCA});
        run_frame("gaps", 5);
        do_restart("gaps");

        wr_q.delete();
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h33); send_byte(8'h03);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_nwr", wr_q.size(), 2);
        check("midrst_we", mem_we, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_hold", cpu_hold, 1);
        load_list('{8'h04, 8'h00, 8'h33, 8'h03, 8'h94, 8'h00, 8'hCA});
        run_frame("afterrst", 0);
        do_restart("afterrst");

        wr_q.delete();
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h33);
`ifdef IMEM_LOADER_TIMEOUT_EN
        tick(TO - 1);
        check("to_early", error, 0);
        tick(1);
        check("to_error", error, 1);
        check("to_code", err_code, 3);
        check("to_hold", cpu_hold, 1);
        check("to_nwr", wr_q.size(), 1);
        do_restart("to");
`else
        tick(3 * TO);
        check("nto_error", error, 0);
        check("nto_ready", in_ready, 1);
        send_byte(8'h03); send_byte(8'h94); send_byte(8'h00); send_byte(8'hCA);
        tick(2);
        check("nto_done", done, 1);
        check("nto_code", err_code, 0);
        check("nto_nwr", wr_q.size(), 4);
        do_restart("nto");
`endif

        for (int f = 0; f < 20; f++) begin
            make_frame($urandom_range(0, 7) == 0 ? $urandom_range(MEM + 1, 300)
                                                 : $urandom_range(0, MEM),
                       $urandom_range(0, 3) == 0);
            run_frame("rand", $urandom_range(0, 3));
            do_restart("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
